// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the MIPS instruction-fetch stage
//   fetch_state_t : fetch FSM encoding (request, wait for data, hold buffered word)
//   RESET_PC      : first fetch address after reset
//   NOP           : instruction word placed in F/D on a bubble
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch stage: one-outstanding imem fetch, stall buffer, F/D register
//   clk, reset (async, active-low)
//   stall_i, redirect_i, target_i            : hazard unit / decode control
//   imem_req_o, imem_addr_o, imem_gnt_i,
//   imem_rvalid_i, imem_rdata_i              : instruction memory handshake
//   op_d_o, pcn_d_o, valid_d_o               : F/D pipeline register
//   pc_f_o                                   : current fetch PC
module fetch_stage
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] op_d_o,
  output logic [31:0] pcn_d_o,
  output logic        valid_d_o,
  output logic [31:0] pc_f_o
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_f;
  logic [31:0]  ibuf;
  logic         redir_pend;
  logic [31:0]  redir_pc;

  logic         avail;
  logic         consume;
  logic [31:0]  instr;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;

  assign pc_plus4    = pc_f + 32'd4;  // wraps modulo 2^32
  assign imem_req_o  = (state == ST_REQ);
  assign imem_addr_o = pc_f;
  assign pc_f_o      = pc_f;

  always_comb begin
    avail      = 1'b0;
    instr      = imem_rdata_i;
    state_next = state;
    // rvalid only counts while a request is outstanding
    case (state)
      ST_WAIT: avail = imem_rvalid_i;
      ST_HOLD: begin
        avail = 1'b1;
        instr = ibuf;
      end
      default: avail = 1'b0;
    endcase
    consume = avail & ~stall_i;

    // A live redirect in the consume cycle wins; otherwise an earlier
    // redirect that arrived before the delay slot was ready is replayed.
    if (redirect_i)      next_pc = target_i;
    else if (redir_pend) next_pc = redir_pc;
    else                 next_pc = pc_plus4;

    case (state)
      ST_REQ:  if (imem_gnt_i) state_next = ST_WAIT;
      ST_WAIT: begin
        if (consume)    state_next = ST_REQ;
        else if (avail) state_next = ST_HOLD;
      end
      ST_HOLD: if (consume) state_next = ST_REQ;
      default: state_next = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_REQ;
      pc_f       <= RESET_PC;
      ibuf       <= 32'd0;
      redir_pend <= 1'b0;
      redir_pc   <= 32'd0;
      op_d_o     <= NOP;
      pcn_d_o    <= 32'd0;
      valid_d_o  <= 1'b0;
    end else begin
      state <= state_next;

      if (consume) begin
        op_d_o    <= instr;
        pcn_d_o   <= pc_plus4;
        valid_d_o <= 1'b1;
        pc_f      <= next_pc;
      end else if (!avail && !stall_i) begin
        // bubble keeps the last pcn so decode never sees a stale PC jump
        op_d_o    <= NOP;
        valid_d_o <= 1'b0;
      end

      if (state == ST_WAIT && avail && stall_i)
        ibuf <= imem_rdata_i;

      // Redirect before the delay slot is ready: remember the target and
      // apply it once the delay slot itself has been consumed.
      if (consume) begin
        redir_pend <= 1'b0;
      end else if (redirect_i && !stall_i) begin
        redir_pend <= 1'b1;
        redir_pc   <= target_i;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] op_d_o;
  logic [31:0] pcn_d_o;
  logic        valid_d_o;
  logic [31:0] pc_f_o;

  int checks;
  int errors;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .target_i      (target_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .op_d_o        (op_d_o),
    .pcn_d_o       (pcn_d_o),
    .valid_d_o     (valid_d_o),
    .pc_f_o        (pc_f_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, then settle 1 time unit past the edge.
  task automatic step(input logic s, input logic r, input logic [31:0] t,
                      input logic g, input logic rv, input logic [31:0] d);
    stall_i       = s;
    redirect_i    = r;
    target_i      = t;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step(0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 32'h0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (op_d_o !== 32'h0) begin errors++; $display("FAIL rst_op got %h exp %h", op_d_o, 32'h0); end
    checks++; if (pcn_d_o !== 32'h0) begin errors++; $display("FAIL rst_pcn got %h exp %h", pcn_d_o, 32'h0); end
    checks++; if (valid_d_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_d_o); end
    checks++; if (pc_f_o !== 32'h3000) begin errors++; $display("FAIL rst_pc got %h exp %h", pc_f_o, 32'h3000); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3000) begin errors++; $display("FAIL rst_req got %b/%h exp 1/%h", imem_req_o, imem_addr_o, 32'h3000); end
  endtask

  task automatic test_zero_wait();
    apply_reset();
    step(0, 0, 32'h0, 1, 0, 32'h0);
    checks++; if (imem_req_o !== 1'b0 || valid_d_o !== 1'b0) begin errors++; $display("FAIL zw_wait1 got req=%b v=%b exp req=0 v=0", imem_req_o, valid_d_o); end
    step(0, 0, 32'h0, 0, 1, 32'h24080001);
    checks++; if (op_d_o !== 32'h24080001 || pcn_d_o !== 32'h3004 || valid_d_o !== 1'b1) begin errors++; $display("FAIL zw_i1 got %h/%h/%b exp 24080001/00003004/1", op_d_o, pcn_d_o, valid_d_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3004) begin errors++; $display("FAIL zw_req2 got %b/%h exp 1/00003004", imem_req_o, imem_addr_o); end
    step(0, 0, 32'h0, 1, 0, 32'h0);
    checks++; if (op_d_o !== 32'h0 || pcn_d_o !== 32'h3004 || valid_d_o !== 1'b0) begin errors++; $display("FAIL zw_bub got %h/%h/%b exp 00000000/00003004/0", op_d_o, pcn_d_o, valid_d_o); end
    step(0, 0, 32'h0, 0, 1, 32'h24090002);
    checks++; if (op_d_o !== 32'h24090002 || pcn_d_o !== 32'h3008 || valid_d_o !== 1'b1) begin errors++; $display("FAIL zw_i2 got %h/%h/%b exp 24090002/00003008/1", op_d_o, pcn_d_o, valid_d_o); end
    checks++; if (imem_addr_o !== 32'h3008) begin errors++; $display("FAIL zw_addr3 got %h exp 00003008", imem_addr_o); end
  endtask

  task automatic test_stall_hold();
    apply_reset();
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h11111111);
    step(1, 0, 32'h0, 1, 0, 32'h0);
    checks++; if (op_d_o !== 32'h11111111 || valid_d_o !== 1'b1) begin errors++; $display("FAIL st_gnt got %h/%b exp 11111111/1", op_d_o, valid_d_o); end
    step(1, 0, 32'h0, 0, 1, 32'h22222222);
    checks++; if (op_d_o !== 32'h11111111 || pcn_d_o !== 32'h3004 || valid_d_o !== 1'b1) begin errors++; $display("FAIL st_hold1 got %h/%h/%b exp 11111111/00003004/1", op_d_o, pcn_d_o, valid_d_o); end
    // stray rvalid while holding must not overwrite the buffered word
    step(1, 0, 32'h0, 0, 1, 32'hDEADBEEF);
    step(1, 0, 32'h0, 0, 0, 32'h0);
    checks++; if (imem_req_o !== 1'b0 || op_d_o !== 32'h11111111) begin errors++; $display("FAIL st_hold3 got req=%b op=%h exp req=0 op=11111111", imem_req_o, op_d_o); end
    step(0, 0, 32'h0, 0, 0, 32'h0);
    checks++; if (op_d_o !== 32'h22222222 || pcn_d_o !== 32'h3008 || valid_d_o !== 1'b1) begin errors++; $display("FAIL st_rel got %h/%h/%b exp 22222222/00003008/1", op_d_o, pcn_d_o, valid_d_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3008) begin errors++; $display("FAIL st_req got %b/%h exp 1/00003008", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_branch_delay_slot();
    apply_reset();
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h10000010);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 1, 32'h3040, 0, 1, 32'h24100005);
    checks++; if (op_d_o !== 32'h24100005 || pcn_d_o !== 32'h3008 || valid_d_o !== 1'b1) begin errors++; $display("FAIL br_ds got %h/%h/%b exp 24100005/00003008/1", op_d_o, pcn_d_o, valid_d_o); end
    checks++; if (imem_addr_o !== 32'h3040 || pc_f_o !== 32'h3040) begin errors++; $display("FAIL br_tgt got %h/%h exp 00003040", imem_addr_o, pc_f_o); end
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h2411000A);
    checks++; if (op_d_o !== 32'h2411000A || pcn_d_o !== 32'h3044) begin errors++; $display("FAIL br_t1 got %h/%h exp 2411000a/00003044", op_d_o, pcn_d_o); end
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h10000020);
    step(0, 1, 32'h3080, 1, 0, 32'h0);
    checks++; if (op_d_o !== 32'h0 || pcn_d_o !== 32'h3004 || valid_d_o !== 1'b0) begin errors++; $display("FAIL rp_bub1 got %h/%h/%b exp 00000000/00003004/0", op_d_o, pcn_d_o, valid_d_o); end
    step(0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 32'h0);
    checks++; if (valid_d_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL rp_bub3 got v=%b req=%b exp v=0 req=0", valid_d_o, imem_req_o); end
    step(0, 0, 32'h0, 0, 1, 32'h24120003);
    checks++; if (op_d_o !== 32'h24120003 || pcn_d_o !== 32'h3008 || valid_d_o !== 1'b1) begin errors++; $display("FAIL rp_ds got %h/%h/%b exp 24120003/00003008/1", op_d_o, pcn_d_o, valid_d_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3080) begin errors++; $display("FAIL rp_tgt got %b/%h exp 1/00003080", imem_req_o, imem_addr_o); end
    // pending redirect must be gone: next sequential fetch follows the target
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h24130004);
    checks++; if (imem_addr_o !== 32'h3084 || pcn_d_o !== 32'h3084) begin errors++; $display("FAIL rp_seq got %h/%h exp 00003084/00003084", imem_addr_o, pcn_d_o); end
  endtask

  task automatic test_gnt_withheld();
    apply_reset();
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h33333333);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 0, 0, 32'h0);
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3004 || op_d_o !== 32'h0 || valid_d_o !== 1'b0 || pcn_d_o !== 32'h3004) begin
        errors++; $display("FAIL ng_cyc%0d got req=%b addr=%h op=%h v=%b pcn=%h exp 1/00003004/00000000/0/00003004", i, imem_req_o, imem_addr_o, op_d_o, valid_d_o, pcn_d_o);
      end
    end
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h44444444);
    checks++; if (op_d_o !== 32'h44444444 || pcn_d_o !== 32'h3008) begin errors++; $display("FAIL ng_done got %h/%h exp 44444444/00003008", op_d_o, pcn_d_o); end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h55555555);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (op_d_o !== 32'h0 || pcn_d_o !== 32'h0 || valid_d_o !== 1'b0 || pc_f_o !== 32'h3000 || imem_req_o !== 1'b1) begin
      errors++; $display("FAIL rw_async got op=%h pcn=%h v=%b pc=%h req=%b exp 0/0/0/00003000/1", op_d_o, pcn_d_o, valid_d_o, pc_f_o, imem_req_o);
    end
    step(0, 0, 32'h0, 0, 0, 32'h0);
    reset = 1'b1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3000) begin errors++; $display("FAIL rw_req got %b/%h exp 1/00003000", imem_req_o, imem_addr_o); end
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h66666666);
    checks++; if (op_d_o !== 32'h66666666 || pcn_d_o !== 32'h3004) begin errors++; $display("FAIL rw_first got %h/%h exp 66666666/00003004", op_d_o, pcn_d_o); end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 1, 32'hFFFFFFFC, 0, 1, 32'h77777777);
    checks++; if (imem_addr_o !== 32'hFFFFFFFC) begin errors++; $display("FAIL wr_tgt got %h exp fffffffc", imem_addr_o); end
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'h88888888);
    checks++; if (pcn_d_o !== 32'h0 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL wr_wrap got %h/%h exp 00000000/00000000", pcn_d_o, imem_addr_o); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    target_i      = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_branch_delay_slot();
    test_redirect_pending();
    test_gnt_withheld();
    test_reset_in_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Holds the fetch PC, issues one-outstanding requests to a handshaked instruction memory, absorbs memory latency and pipeline stalls with a one-entry buffer, and drives the F/D pipeline register (instruction, PC+4, valid) consumed by decode. Branch/jump redirects from decode are applied after the delay-slot instruction, preserving MIPS delay-slot semantics.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- NOP, 32'h0000_0000, instruction word driven into F/D on a bubble
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- stall_i  in  1  hazard unit: hold F/D and PC this cycle
- redirect_i  in  1  decode: branch taken or jump (ignored when stall_i=1)
- target_i  in  32  decode: redirect target address
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address (word aligned)
- imem_gnt_i  in  1  memory accepted request this cycle
- imem_rvalid_i  in  1  read data valid; earliest one cycle after gnt
- imem_rdata_i  in  32  instruction word
- op_d_o  out  32  F/D instruction
- pcn_d_o  out  32  F/D PC+4 of that instruction
- valid_d_o  out  1  F/D holds a real instruction (0 = bubble)
- pc_f_o  out  32  current fetch PC (debug)

## Operation
- FSM states: REQ, WAIT, HOLD. Registers: pc_f, ibuf[31:0], redir_pend, redir_pc, F/D {op, pcn, valid}.
- REQ: imem_req_o=1, imem_addr_o=pc_f. gnt -> WAIT; else stay.
- WAIT: imem_req_o=0. rvalid -> instruction available (imem_rdata_i).
- HOLD: instruction available from ibuf.
- avail = (WAIT & rvalid) | HOLD.
- avail & !stall_i (consume): F/D <= {instr, pc_f+4, 1}; pc_f <= next; state -> REQ.
- avail & stall_i: F/D held; ibuf <= instr if in WAIT; state -> HOLD.
- !avail & !stall_i: F/D <= {NOP, pcn_d_o unchanged, 0} (bubble).
- !avail & stall_i: F/D held.
- next = redirect_i ? target_i : redir_pend ? redir_pc : pc_f+4; consume clears redir_pend.
- redirect_i & !stall_i & !consume: redir_pend <= 1, redir_pc <= target_i (delay slot still in flight; branch leaves decode, bubbles follow, delay slot, then target).
- redirect_i while redir_pend=1: new target overwrites (branch in delay slot is architecturally undefined).
- pc_f+4 wraps modulo 2^32; no alignment check.

## Timing
- Reset values: state=REQ, pc_f=RESET_PC, op_d_o=NOP, pcn_d_o=0, valid_d_o=0, redir_pend=0, redir_pc=0, ibuf=0; imem_req_o=1 on first cycle after reset release.
- Zero-wait memory (gnt with req, rvalid next cycle): one instruction per 2 cycles; each extra wait cycle adds one bubble.
- F/D outputs are registered; stall_i, redirect_i, target_i sampled at the consume edge.
- Reset mid-request abandons the transaction; imem shares reset, so no stale rvalid arrives.
- rvalid outside WAIT is ignored.

## Structure
- Package fetch_pkg: state enum {REQ, WAIT, HOLD}, RESET_PC and NOP defaults.
- No sub-module; FSM, PC logic and F/D register live in one module.

## Test plan
- Reset release, zero-wait memory returning 0x24080001, 0x24090002 -> F/D shows op 0x24080001/pcn 0x3004 then 0x24090002/pcn 0x3008, valid pulses every 2nd cycle, bubbles between.
- stall_i high 3 cycles while rvalid arrives in WAIT -> state HOLD, F/D unchanged; on release, buffered word enters F/D, next req address = pc_f+4.
- Branch at 0x3000: redirect_i=1, target 0x3040 in cycle delay slot (0x3004) is consumed -> F/D 0x3004 instruction, next imem_addr_o=0x3040.
- Redirect to 0x3080 while delay-slot fetch still in WAIT (3-cycle latency) -> redir_pend set, bubbles, delay slot enters F/D, next imem_addr_o=0x3080.
- Memory withholds gnt for 4 cycles -> imem_req_o and imem_addr_o stable, F/D bubbles (NOP, valid=0).
- Assert reset while in WAIT -> all outputs to reset values immediately; after release first request at 0x3000.
